// File: rtl/aes_sbox.sv
// AES SubBytes unit: masked forward S-box substitution of a NO_ROWS x NO_COLS
// state matrix, registered one edge after sbox_en is sampled high.
module aes_sbox #(
  parameter int NO_ROWS = 4,
  parameter int NO_COLS = 4
) (
  input  logic       aes_clk,
  input  logic       resetn,
  input  logic       sbox_en,
  input  logic [7:0] sbox_ip_char_matrix [NO_ROWS][NO_COLS],
  input  logic [3:0] sbox_ip_char_row_mask,
  input  logic [3:0] sbox_ip_char_col_mask,
  output logic       sbox_op_char_matrix_valid,
  output logic [7:0] sbox_op_char_matrix [NO_ROWS][NO_COLS]
);

  // Forward S-box, indexed directly by the input byte (high nibble selects row).
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {IDLE, DONE} state_t;

  state_t     state_q;
  logic [7:0] matrix_d [NO_ROWS][NO_COLS];
  logic [7:0] matrix_q [NO_ROWS][NO_COLS];

  // Mask bits at or above NO_ROWS/NO_COLS are never indexed, so they are ignored.
  for (genvar i = 0; i < NO_ROWS; i++) begin : g_row
    for (genvar j = 0; j < NO_COLS; j++) begin : g_col
      assign matrix_d[i][j] = (sbox_ip_char_row_mask[i] && sbox_ip_char_col_mask[j])
                              ? SBOX[sbox_ip_char_matrix[i][j]]
                              : sbox_ip_char_matrix[i][j];
    end
  end

  // Handshake: sbox_en is a level request; each edge it is high refreshes the
  // matrix and holds valid=1, and the first edge it is low drops valid while the
  // matrix keeps its last value for the core to read.
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      matrix_q <= '{default: 8'h00};
    end else begin
      case (state_q)
        IDLE: begin
          if (sbox_en) begin
            state_q  <= DONE;
            matrix_q <= matrix_d;
          end
        end
        DONE: begin
          if (sbox_en) begin
            matrix_q <= matrix_d;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sbox_op_char_matrix_valid = (state_q == DONE);
  assign sbox_op_char_matrix       = matrix_q;

endmodule

// File: tb/tb_aes_sbox.sv
// Bench for aes_sbox: reference S-box built from GF(2^8) inversion plus the
// affine map, scoreboard queue of {valid, matrix} predictions, directed steps.
module tb_aes_sbox;
  localparam int W = 129;

  logic       aes_clk = 1'b0;
  logic       resetn  = 1'b1;
  logic       sbox_en = 1'b0;
  logic [7:0] in_m  [4][4];
  logic [7:0] out_m [4][4];
  logic [3:0] row_mask = 4'h0;
  logic [3:0] col_mask = 4'h0;
  logic       valid;

  logic [7:0]   ref_sbox [256];
  logic [127:0] last_m = '0;
  logic [W-1:0] exp_q [$];
  int           pass_cnt = 0;
  int           fail_cnt = 0;
  int           total_cnt = 0;

  aes_sbox #(.NO_ROWS(4), .NO_COLS(4)) dut (
    .aes_clk                   (aes_clk),
    .resetn                    (resetn),
    .sbox_en                   (sbox_en),
    .sbox_ip_char_matrix       (in_m),
    .sbox_ip_char_row_mask     (row_mask),
    .sbox_ip_char_col_mask     (col_mask),
    .sbox_op_char_matrix_valid (valid),
    .sbox_op_char_matrix       (out_m)
  );

  initial forever #5 aes_clk = ~aes_clk;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      if (a[7]) a = {a[6:0], 1'b0} ^ 8'h1b;
      else      a = {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_ref();
    logic [7:0] xb, yb, inv, r, s;
    for (int x = 0; x < 256; x++) begin
      xb  = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = y[7:0];
        if (xb != 8'h00 && gmul(xb, yb) == 8'h01) inv = yb;
      end
      s = inv ^ 8'h63;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      ref_sbox[x] = s;
    end
  endtask

  function automatic logic [127:0] model_m();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        v[(i*4+j)*8 +: 8] = (row_mask[i] && col_mask[j]) ? ref_sbox[in_m[i][j]] : in_m[i][j];
    return v;
  endfunction

  function automatic logic [W-1:0] observed();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        v[(i*4+j)*8 +: 8] = out_m[i][j];
    return {valid, v};
  endfunction

  task automatic check_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    if (exp_q.size() == 0) begin
      total_cnt++;
      fail_cnt++;
      $error("FAIL %s observed=empty_queue expected=prediction", tag);
    end else begin
      check_w(tag, observed(), exp_q.pop_front());
    end
  endtask

  task automatic step(input logic en, input string tag);
    @(negedge aes_clk);
    sbox_en = en;
    if (en) last_m = model_m();
    exp_q.push_back({en, last_m});
    @(posedge aes_clk);
    #1;
    check_out(tag);
  endtask

  task automatic fill(input logic [7:0] b);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        in_m[i][j] = b;
  endtask

  initial begin
    logic [7:0] bb;
    fill(8'h00);
    build_ref();

    // Asynchronous reset mid-cycle, before any clock edge.
    #2 resetn = 1'b0;
    #1 check_w("reset_async", observed(), '0);
    @(posedge aes_clk); @(posedge aes_clk);
    @(negedge aes_clk) resetn = 1'b1;
    step(1'b0, "idle_after_reset");
    step(1'b0, "idle_after_reset2");

    // Full substitution.
    row_mask = 4'hF; col_mask = 4'hF;
    in_m[0] = '{8'h00, 8'h01, 8'h10, 8'h19};
    in_m[1] = '{8'h53, 8'hFF, 8'hC9, 8'h7C};
    step(1'b1, "full_sub");
    check8("full_00", out_m[0][0], 8'h63);
    check8("full_03", out_m[0][3], 8'hD4);
    check8("full_10", out_m[1][0], 8'hED);
    check8("full_13", out_m[1][3], 8'h10);
    check8("full_33", out_m[3][3], 8'h63);
    step(1'b0, "full_drop");
    step(1'b0, "full_idle");

    // Masking: only [0][1] substituted.
    fill(8'h53);
    row_mask = 4'b0001; col_mask = 4'b0010;
    step(1'b1, "mask");
    check8("mask_01", out_m[0][1], 8'hED);
    check8("mask_00", out_m[0][0], 8'h53);
    check8("mask_11", out_m[1][1], 8'h53);
    step(1'b0, "mask_drop");
    step(1'b0, "mask_idle");

    // Handshake tracking with 1-cycle latency, then hold after drop.
    fill(8'h00);
    row_mask = 4'hF; col_mask = 4'hF;
    step(1'b1, "track0");
    check8("track0_00", out_m[0][0], 8'h63);
    in_m[0][0] = 8'hFF;
    step(1'b1, "track1");
    check8("track1_00", out_m[0][0], 8'h16);
    in_m[0][0] = 8'h01;
    step(1'b1, "track2");
    check8("track2_00", out_m[0][0], 8'h7C);
    in_m[0][0] = 8'h55;
    step(1'b0, "track_drop");
    check8("hold_00", out_m[0][0], 8'h7C);
    step(1'b0, "track_idle");

    // Exhaustive byte sweep with full masks.
    for (int b = 0; b < 256; b++) begin
      bb = b[7:0];
      fill(bb);
      step(1'b1, "exhaustive");
      if (bb == 8'h9A) check8("spot_9a", out_m[2][1], 8'hB8);
      if (bb == 8'h3C) check8("spot_3c", out_m[1][2], 8'hEB);
      if (bb == 8'h80) check8("spot_80", out_m[3][0], 8'hCD);
    end
    step(1'b0, "exh_drop");
    step(1'b0, "exh_idle");

    // Random inputs and masks, including changes at the enabling edge.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          in_m[i][j] = 8'($urandom_range(0, 255));
      row_mask = 4'($urandom_range(0, 15));
      col_mask = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 3) != 0), "random");
    end
    step(1'b0, "rand_drop");
    step(1'b0, "rand_idle");

    // Reset while in DONE, then recovery with sbox_en held high.
    fill(8'hA5);
    row_mask = 4'hF; col_mask = 4'hF;
    step(1'b1, "pre_reset_done");
    #2 resetn = 1'b0;
    #1 check_w("reset_in_done", observed(), '0);
    last_m = '0;
    @(negedge aes_clk);
    resetn = 1'b1;
    last_m = model_m();
    exp_q.push_back({1'b1, last_m});
    @(posedge aes_clk);
    #1;
    check_out("reset_recover");
    check8("recover_00", out_m[0][0], 8'h06);
    step(1'b0, "recover_drop");

    if (exp_q.size() != 0) begin
      total_cnt++;
      fail_cnt++;
      $error("FAIL leftover_queue observed=%0d expected=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
